irq_ctrl: RTL and testbench

//  Interrupt controller for the single-cycle Beta-style core. Collects NUM_SRC external

---
 rtl/irq_ctrl.sv | 155 +++++++++++++++
 tb/tb_irq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and edge/level-detects NUM_SRC sources, masks them,
// picks the lowest-index winner and runs a REQ/ACK/EOI handshake with the core.
module irq_ctrl #(
   parameter int                 NUM_SRC     = 8,
   parameter int                 ID_W        = 3,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}},
   parameter logic [NUM_SRC-1:0] MASK_INIT   = {NUM_SRC{1'b0}}
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wd,
   output logic [NUM_SRC-1:0] mask,
   input  logic               kernel_mode,
   output logic               irq,
   input  logic               irq_ack,
   input  logic               eoi,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] pending,
   output logic               active
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [ID_W-1:0]    id_r, id_nxt_s, win_s;
   logic [NUM_SRC-1:0] smp_s, prev_r, rise_s;
   logic [NUM_SRC-1:0] pend_r, pend_cur_s, pend_nxt_s, ack_clr_s;
   logic [NUM_SRC-1:0] eligible_s, mask_r;
   logic               ack_take_s, irq_r, active_r;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign smp_s = irq_src;
      end else begin : g_sync
         logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];

         // Synchroniser shift chain for asynchronous sources.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {NUM_SRC{1'b0}};
            end else begin
               sync_r[0] <= irq_src;
               for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            end
         end

         assign smp_s = sync_r[SYNC_STAGES-1];
      end
   endgenerate

   // Arbitration sees this cycle's new edges so a request can leave IDLE on the edge
   // that also records them in the pending register.
   assign rise_s     = smp_s & ~prev_r;
   assign pend_cur_s = (EDGE_MASK & (pend_r | rise_s)) | (~EDGE_MASK & smp_s);
   assign eligible_s = pend_cur_s & mask_r;
   // A rising edge landing in the ACK cycle survives the clear (set wins).
   assign pend_nxt_s = (EDGE_MASK & ((pend_r & ~ack_clr_s) | rise_s)) | (~EDGE_MASK & smp_s);

   // Lowest-index eligible source wins.
   always_comb begin
      win_s = {ID_W{1'b0}};
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible_s[i]) begin
            win_s = ID_W'(i);
         end else begin
            win_s = win_s;
         end
      end
   end

   // Pending bit cleared by a granted acknowledge (edge sources only).
   always_comb begin
      ack_clr_s = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ack_take_s && (id_r == ID_W'(i)) && EDGE_MASK[i]) begin
            ack_clr_s[i] = 1'b1;
         end else begin
            ack_clr_s[i] = 1'b0;
         end
      end
   end

   // Handshake next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      id_nxt_s    = id_r;
      ack_take_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if ((|eligible_s) && !kernel_mode) begin
               state_nxt_s = ST_REQ;
               id_nxt_s    = win_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               state_nxt_s = ST_SERVICE;
               ack_take_s  = 1'b1;
            end else if (!eligible_s[id_r]) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_SERVICE: begin
            if (eoi) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SERVICE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            id_nxt_s    = {ID_W{1'b0}};
         end
      endcase
   end

   // State, pending, mask and registered handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= ST_IDLE;
         id_r     <= {ID_W{1'b0}};
         prev_r   <= {NUM_SRC{1'b0}};
         pend_r   <= {NUM_SRC{1'b0}};
         mask_r   <= MASK_INIT;
         irq_r    <= 1'b0;
         active_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         id_r     <= id_nxt_s;
         prev_r   <= smp_s;
         pend_r   <= pend_nxt_s;
         mask_r   <= mask_we ? mask_wd : mask_r;
         irq_r    <= (state_nxt_s == ST_REQ);
         active_r <= (state_nxt_s == ST_SERVICE);
      end
   end

   assign mask    = mask_r;
   assign irq     = irq_r;
   assign irq_id  = id_r;
   assign pending = pend_r;
   assign active  = active_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scenario bench for irq_ctrl: expected request IDs are queued when sources are driven
// and popped when the controller raises IRQ.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irq_src;
   logic       mask_we;
   logic [7:0] mask_wd;
   logic [7:0] mask;
   logic       kernel_mode;
   logic       irq;
   logic       irq_ack;
   logic       eoi;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic       active;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   irq_ctrl #(
      .NUM_SRC(8), .ID_W(3), .SYNC_STAGES(2), .EDGE_MASK(8'hF7), .MASK_INIT(8'h00)
   ) dut (
      .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .mask_we(mask_we),
      .mask_wd(mask_wd), .mask(mask), .kernel_mode(kernel_mode), .irq(irq),
      .irq_ack(irq_ack), .eoi(eoi), .irq_id(irq_id), .pending(pending), .active(active)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_mask(input logic [7:0] v);
      mask_wd = v; mask_we = 1'b1;
      @(negedge clk);
      mask_we = 1'b0;
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1;
      @(negedge clk);
      eoi = 1'b0;
   endtask

   // Waits up to budget negedges for IRQ, then pops the scoreboard and compares the ID.
   task automatic wait_irq(input string name, input int budget);
      int n;
      int exp;
      n = 0;
      while (!irq && n < budget) begin
         @(negedge clk);
         n++;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL %s irq: got %b, expected 1 within %0d cycles", name, irq, budget);
      end else begin
         checks++;
         if ({29'd0, irq_id} !== exp) begin
            errors++;
            $display("FAIL %s irq_id: got %0d, expected %0d", name, irq_id, exp);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; irq_src = 8'h00; mask_we = 1'b0; mask_wd = 8'h00;
      kernel_mode = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
      #1;
      checks++;
      if ({irq, active, pending, mask, irq_id} !== {1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
         errors++;
         $display("FAIL reset_init: got irq=%b active=%b pend=%h mask=%h id=%0d, expected 0/0/00/00/0",
                  irq, active, pending, mask, irq_id);
      end
      cyc(2);
      reset_n = 1'b1;
      write_mask(8'hFF);
      irq_src[1] = 1'b1; exp_q.push_back(1);
      @(negedge clk);
      irq_src[1] = 1'b0;
      wait_irq("reset_setup", 4);
      do_ack();
      irq_src[2] = 1'b1; irq_src[3] = 1'b1;
      @(negedge clk);
      irq_src[2] = 1'b0;
      cyc(3);
      checks++;
      if ({active, pending} !== {1'b1, 8'h0C}) begin
         errors++;
         $display("FAIL reset_pre: got active=%b pend=%h, expected 1/0c", active, pending);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({irq, active, pending, mask, irq_id} !== {1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
         errors++;
         $display("FAIL reset_mid: got irq=%b active=%b pend=%h mask=%h id=%0d, expected 0/0/00/00/0",
                  irq, active, pending, mask, irq_id);
      end
      irq_src = 8'h00;
      cyc(2);
      reset_n = 1'b1;
      cyc(4);
      checks++;
      if ({irq, pending} !== {1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_exit: got irq=%b pend=%h, expected 0/00", irq, pending);
      end
   endtask

   task automatic test_basic();
      write_mask(8'hFF);
      irq_src[5] = 1'b1; exp_q.push_back(5);
      @(negedge clk);
      irq_src[5] = 1'b0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL basic_lat1: got irq=%b, expected 0", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL basic_lat2: got irq=%b, expected 0", irq); end
      wait_irq("basic_lat3", 1);
      do_ack();
      checks++;
      if ({irq, active, pending[5]} !== 3'b010) begin
         errors++;
         $display("FAIL basic_ack: got irq=%b active=%b pend5=%b, expected 0/1/0", irq, active, pending[5]);
      end
      do_eoi();
      cyc(2);
      checks++;
      if ({irq, active} !== 2'b00) begin
         errors++;
         $display("FAIL basic_eoi: got irq=%b active=%b, expected 0/0", irq, active);
      end
      do_ack();
      checks++;
      if ({irq, active} !== 2'b00) begin
         errors++;
         $display("FAIL basic_stray_ack: got irq=%b active=%b, expected 0/0", irq, active);
      end
   endtask

   task automatic test_priority();
      irq_src[6] = 1'b1; irq_src[2] = 1'b1;
      exp_q.push_back(2); exp_q.push_back(6);
      @(negedge clk);
      irq_src[6] = 1'b0; irq_src[2] = 1'b0;
      wait_irq("prio_first", 4);
      checks++;
      if (pending !== 8'h44) begin errors++; $display("FAIL prio_pend: got %h, expected 44", pending); end
      do_ack();
      checks++;
      if (pending !== 8'h40) begin errors++; $display("FAIL prio_ack_pend: got %h, expected 40", pending); end
      do_eoi();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL prio_eoi_idle: got irq=%b, expected 0", irq); end
      wait_irq("prio_second", 1);
      do_ack();
      do_eoi();
      cyc(2);
   endtask

   task automatic test_mask_kernel();
      write_mask(8'hFE);
      irq_src[0] = 1'b1;
      @(negedge clk);
      irq_src[0] = 1'b0;
      cyc(4);
      checks++;
      if ({irq, pending[0]} !== 2'b01) begin
         errors++;
         $display("FAIL mask_block: got irq=%b pend0=%b, expected 0/1", irq, pending[0]);
      end
      kernel_mode = 1'b1;
      write_mask(8'hFF);
      cyc(3);
      checks++;
      if ({irq, mask} !== {1'b0, 8'hFF}) begin
         errors++;
         $display("FAIL kernel_block: got irq=%b mask=%h, expected 0/ff", irq, mask);
      end
      kernel_mode = 1'b0; exp_q.push_back(0);
      wait_irq("kernel_release", 1);
      do_ack();
      do_eoi();
      cyc(2);
   endtask

   task automatic test_level_withdraw();
      int n;
      irq_src[3] = 1'b1; exp_q.push_back(3);
      wait_irq("level_req", 4);
      irq_src[3] = 1'b0;
      n = 0;
      while (irq && n < 5) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({irq, active, pending[3]} !== 3'b000) begin
         errors++;
         $display("FAIL level_withdraw: got irq=%b active=%b pend3=%b, expected 0/0/0",
                  irq, active, pending[3]);
      end
      cyc(2);
   endtask

   task automatic test_collision();
      irq_src[4] = 1'b1; exp_q.push_back(4);
      @(negedge clk);
      irq_src[4] = 1'b0;
      wait_irq("coll_req", 4);
      irq_src[4] = 1'b1;
      cyc(2);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0; irq_src[4] = 1'b0;
      checks++;
      if ({active, pending[4]} !== 2'b11) begin
         errors++;
         $display("FAIL coll_setwins: got active=%b pend4=%b, expected 1/1", active, pending[4]);
      end
      exp_q.push_back(4);
      do_eoi();
      wait_irq("coll_rearm", 1);
      do_ack();
      do_eoi();
      cyc(3);
      checks++;
      if ({irq, pending} !== {1'b0, 8'h00}) begin
         errors++;
         $display("FAIL coll_final: got irq=%b pend=%h, expected 0/00", irq, pending);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask_kernel();
      test_level_withdraw();
      test_collision();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
